// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a 1R/1W word memory, with registered read-return routing.
// Optional master lock for read-modify-write sequences is enabled by defining ARB_LOCK_EN.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {LK_NONE = 2'd0, LK_M0 = 2'd1, LK_M1 = 2'd2} lock_e;

  lock_e       lock_own, lock_nxt;
  logic        prio, rd_owner, rd_pend;
  logic [1:0]  req, gnt;
  logic        any, win, win_we, win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign req = {m1_req, m0_req};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio     <= 1'b0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      lock_own <= LK_NONE;
    end else begin
      lock_own <= lock_nxt;
      rd_pend  <= any & ~win_we;
      if (any) prio <= ~win;
      if (any & ~win_we) rd_owner <= win;
    end
  end

  // Next-state for lock ownership
`ifdef ARB_LOCK_EN
  always_comb begin
    lock_nxt = lock_own;
    case (lock_own)
      LK_M0:   if (!m0_req || (gnt[0] && !m0_lock)) lock_nxt = LK_NONE;
      LK_M1:   if (!m1_req || (gnt[1] && !m1_lock)) lock_nxt = LK_NONE;
      default: if (any && win_lock) lock_nxt = win ? LK_M1 : LK_M0;
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock ^ win_lock;
  always_comb lock_nxt = LK_NONE;
`endif

  // Arbitration and memory drive
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (lock_own)
        LK_M0:   gnt[0] = req[0];
        LK_M1:   gnt[1] = req[1];
        default: begin
          if (&req) gnt[prio] = 1'b1;
          else      gnt = req;
        end
      endcase
    end
  end

  assign any       = |gnt;
  assign win       = gnt[1];
  assign win_we    = win ? m1_we    : m0_we;
  assign win_lock  = win ? m1_lock  : m0_lock;
  assign win_addr  = win ? m1_addr  : m0_addr;
  assign win_wdata = win ? m1_wdata : m0_wdata;

  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (any) begin
      if (win_we) begin
        mem_wen   = 1'b1;
        mem_waddr = win_addr;
        mem_wdata = win_wdata;
      end else begin
        mem_ren   = 1'b1;
        mem_raddr = win_addr;
      end
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Read data is routed to whoever issued the read one cycle earlier
  assign m0_rvalid = rd_pend & ~rd_owner;
  assign m1_rvalid = rd_pend &  rd_owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered-read memory model behind it.
// Lock expectations switch on ARB_LOCK_EN.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [ADDR_W-1:0] m0_addr, m1_addr, mem_waddr, mem_raddr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wen, mem_ren;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: write at edge, registered read
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr[7:0]] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_raddr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input logic lock);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input logic lock);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  logic [4:0] exp_win;
  logic       prev_win;

  initial begin
    rst = 1'b1;
    drv0(1'b1, 1'b1, 16'h0004, 32'h55, 1'b0);
    drv1(1'b1, 1'b0, 16'h0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_ren", mem_ren, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    chk("rst_waddr", mem_waddr, 0);

    // Write then read back from m0
    next_cycle(); rst = 1'b0;
    drv1(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("wr_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("wr_wen", {mem_wen, mem_ren}, 2'b10);
    chk("wr_waddr", mem_waddr, 16'h0004);
    chk("wr_wdata", mem_wdata, 32'h55);
    next_cycle(); drv0(1'b1, 1'b1, 16'h0001, 32'h5, 1'b0);
    @(negedge clk); chk("pre1_gnt", m0_gnt, 1);
    next_cycle(); drv0(1'b1, 1'b1, 16'h0002, 32'h6, 1'b0);
    @(negedge clk); chk("pre2_gnt", m0_gnt, 1);
    next_cycle(); drv0(1'b1, 1'b0, 16'h0004, 32'h0, 1'b0);
    @(negedge clk);
    chk("rd_gnt", m0_gnt, 1);
    chk("rd_ren", {mem_wen, mem_ren}, 2'b01);
    chk("rd_raddr", mem_raddr, 16'h0004);
    chk("rd_rvalid_early", m0_rvalid, 0);
    next_cycle(); drv0(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rd_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
    chk("rd_rdata", m0_rdata, 32'h55);
    chk("rd_m1_rdata", m1_rdata, 0);
    chk("idle_bus", {mem_wen, mem_ren, mem_raddr}, 0);

    // Read grant, then reset in the following cycle
    next_cycle(); drv0(1'b1, 1'b0, 16'h0001, 32'h0, 1'b0);
    @(negedge clk); chk("pre_rst_gnt", {m1_gnt, m0_gnt}, 2'b01);
    next_cycle(); rst = 1'b1;
    drv1(1'b1, 1'b0, 16'h0002, 32'h0, 1'b0);
    @(negedge clk);
    chk("midrst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    chk("midrst_en", {mem_wen, mem_ren}, 0);
    chk("midrst_gnt", {m1_gnt, m0_gnt}, 0);

    // Both reading continuously: alternate from M0, data to the right owner
    next_cycle(); rst = 1'b0;
    prev_win = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      chk($sformatf("alt_gnt%0d", k), {m1_gnt, m0_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 0) chk("alt_rvalid0", {m1_rvalid, m0_rvalid}, 0);
      else begin
        chk($sformatf("alt_rvalid%0d", k), {m1_rvalid, m0_rvalid}, prev_win ? 2'b10 : 2'b01);
        chk($sformatf("alt_rdata%0d", k), prev_win ? m1_rdata : m0_rdata, prev_win ? 32'h6 : 32'h5);
        chk($sformatf("alt_other%0d", k), prev_win ? m0_rdata : m1_rdata, 0);
      end
      prev_win = (k % 2 == 1);
    end

    // m1 read, then m0 write: rvalid to m1 alongside m0 grant
    next_cycle(); drv0(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    @(negedge clk); chk("s3_m1_gnt", {m1_gnt, m0_gnt}, 2'b10);
    next_cycle(); drv0(1'b1, 1'b1, 16'h0008, 32'h77, 1'b0);
    drv1(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("s3_m0_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("s3_wen", mem_wen, 1);
    chk("s3_m1_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
    chk("s3_m1_rdata", m1_rdata, 32'h6);
    chk("s3_m0_rdata", m0_rdata, 0);

    // Lock: m1 locked read, then both requesting
    next_cycle(); drv0(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    drv1(1'b1, 1'b0, 16'h0002, 32'h0, 1'b1);
    @(negedge clk); chk("lk_first", {m1_gnt, m0_gnt}, 2'b10);
`ifdef ARB_LOCK_EN
    exp_win = 5'b01111;
`else
    exp_win = 5'b01010;
`endif
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      drv0(1'b1, 1'b0, 16'h0001, 32'h0, 1'b0);
      drv1(1'b1, 1'b0, 16'h0002, 32'h0, (k < 3));
      @(negedge clk);
      chk($sformatf("lk_gnt%0d", k), {m1_gnt, m0_gnt}, exp_win[k] ? 2'b10 : 2'b01);
    end

    next_cycle();
    drv0(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    drv1(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("end_idle", {m1_gnt, m0_gnt, mem_wen, mem_ren}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter in front of the single-port-per-direction word memory. It multiplexes requests from two masters (m0, m1) onto the memory's read and write ports, issuing one transaction per cycle. Read data is returned to the requester that issued the read, with a registered owner tag. An optional lock holds the memory for one master across consecutive transactions, for read-modify-write.

## Interface
- ADDR_W, 16, address width (matches memory waddr/raddr)
- DATA_W, 32, data width (matches memory wdata/rdata)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous reset, active-high
- m0_req, m1_req  input  1  transaction request, held until granted
- m0_we, m1_we  input  1  1 = write, 0 = read
- m0_addr, m1_addr  input  ADDR_W  word address
- m0_wdata, m1_wdata  input  DATA_W  write data
- m0_lock, m1_lock  input  1  keep ownership after this transaction (ARB_LOCK_EN only)
- m0_gnt, m1_gnt  output  1  request accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  output  1  read data valid this cycle (registered)
- m0_rdata, m1_rdata  output  DATA_W  read data, 0 when matching rvalid low
- mem_waddr, mem_wdata, mem_wen  output  ADDR_W/DATA_W/1  to memory write port
- mem_raddr, mem_ren  output  ADDR_W/1  to memory read port
- mem_rdata  input  DATA_W  from memory, registered inside memory (1-cycle latency)

## Operation
- State: prio (1 bit, requester favoured on conflict), rd_owner (1 bit) plus rd_pend (1 bit), lock_own (2 bits: NONE, M0, M1).
- Arbitration, combinational, each cycle:
  - if lock_own = Mx: only mx may be granted; the other requester waits.
  - else if only one req high: that requester wins.
  - else if both high: requester `prio` wins.
- At most one gnt high per cycle. A winner has gnt=1 in the same cycle; the requester may change req/addr/data in the next cycle.
- Memory drive: winner with we=1 gets mem_wen=1, mem_waddr=addr, mem_wdata=wdata, mem_ren=0. Winner with we=0 gets mem_ren=1, mem_raddr=addr, mem_wen=0. With no winner, mem_wen=mem_ren=0 and address/data buses are 0.
- On each grant to mx: prio ← the other requester. With no grant, prio holds.
- On a read grant: rd_pend ← 1 and rd_owner ← winner; otherwise rd_pend ← 0.
- Next cycle: m{rd_owner}_rvalid = rd_pend; m{rd_owner}_rdata = mem_rdata. The other requester's rdata = 0.
- While rst is high: all gnt, mem_wen and mem_ren are forced 0.

## Timing
- Reset values: prio=M0, rd_pend=0, lock_own=NONE. Hence all gnt=0, rvalid=0, rdata=0, mem_wen=0, mem_ren=0, mem buses 0.
- Grant latency: 0 cycles from req when uncontended.
- Read latency: read granted in cycle N gives rvalid/rdata in cycle N+1.
- Write: the memory updates at the end of cycle N. A read of the same address granted in N+1 returns the new data.
- Back-to-back reads: a new read can be granted in N+1 while the rvalid for the N read is presented. Throughput is 1 transaction per cycle.
- Both requesting continuously: strict alternation M0, M1, M0, … starting from prio.
- Reset asserted mid-read: the pending rvalid is lost; rvalid is 0 on the first cycle after reset release.

## Configuration
- ARB_LOCK_EN defined:
  - A granted transaction with mx_lock=1 sets lock_own ← Mx.
  - lock_own returns to NONE when Mx is granted with lock=0, or when mx_req is low for a cycle while it owns the lock.
  - While locked, the other requester is never granted. prio still updates normally.
- ARB_LOCK_EN undefined: m*_lock ports are present but ignored, and lock_own stays NONE permanently.

## Test plan
- Reset, then m0 write addr 0x0004 data 0x55 → m0_gnt=1 same cycle, mem_wen=1. A following m0 read of 0x0004 → m0_rvalid=1, m0_rdata=0x55 one cycle after grant; m1_rvalid=0.
- Both request reads continuously from reset (m0 addr 1, m1 addr 2, memory preloaded 5/6) → grants M0, M1, M0… alternate. Rdata returns 5, 6, 5… each to the correct owner, one cycle after each grant.
- m1 read granted in cycle N, m0 write granted in N+1 → m1_rvalid=1 in N+1 alongside m0_gnt=1. No data appears on m0_rdata.
- Assert rst in the cycle after a read grant → rvalid=0 and all mem enables 0 immediately. prio=M0 after release.
- ARB_LOCK_EN: m1 read with lock=1, then m0 and m1 both requesting → m1 granted on every cycle until m1 issues with lock=0. m0 is granted in the following cycle.
- ARB_LOCK_EN undefined: same stimulus → alternation as in the second scenario, with lock ignored.
